dom_dep_word: RTL and testbench

- W-bit-wide, order-D domain-oriented-masking dependent AND gadget with a valid/ready streaming interface.
- Computes c = a & b bitwise on Boolean-shared operands. Operand b may be correlated with a; it is remasked with fresh r1, unmasked only after a register stage, and multiplied in public form.
- Cross-domain terms a·r1 use a DOM-indep multiplication refreshed with r2.
- Sits between the masked datapath and downstream masked logic. Back-pressure-aware, optional output register.

---
 rtl/dom_pkg.sv | 20 ++
 rtl/dom_dep_bit.sv | 64 ++++++
 rtl/dom_dep_word.sv | 94 +++++++++
 tb/tb_dom_dep_word.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_pkg.sv
// rtl/dom_pkg.sv - share packing and r2 pair indexing helpers for the DOM dependent AND gadget
package dom_pkg;

  localparam int DEF_D = 2;
  localparam int DEF_W = 8;

  function automatic int n_pairs(input int d);
    return ((d + 1) * d) / 2;
  endfunction

  // Row-major enumeration of the strict upper triangle: (0,1),(0,2)..(1,2)..
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int share_lsb(input int k, input int i, input int n);
    return k * n + i;
  endfunction

endpackage

// File: rtl/dom_dep_bit.sv
// rtl/dom_dep_bit.sv - one bit slice: remask b, DOM-indep cross terms, stage-1 registers and combine
module dom_dep_bit import dom_pkg::*; #(
  parameter int N = 3,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] r1,
  input  logic [L-1:0] r2,
  output logic [N-1:0] c
);

  logic [N-1:0]         z_q, z_d;
  logic [N-1:0]         a_q, a_d;
  logic [N-1:0][N-1:0]  t_q, t_d;
  logic                 zpub;

  always_comb begin
    z_d = z_q;
    a_d = a_q;
    t_d = t_q;
    if (ld) begin
      z_d = b ^ r1;
      a_d = a;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i == j)
            t_d[i][j] = a[i] & r1[j];
          else if (i < j)
            t_d[i][j] = (a[i] & r1[j]) ^ r2[pair_idx(i, j, N)];
          else
            t_d[i][j] = (a[i] & r1[j]) ^ r2[pair_idx(j, i, N)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
      a_q <= '0;
      t_q <= '0;
    end else begin
      z_q <= z_d;
      a_q <= a_d;
      t_q <= t_d;
    end
  end

  // b is only unmasked from register outputs, never from the raw inputs
  always_comb begin
    c    = '0;
    zpub = ^z_q;
    for (int i = 0; i < N; i++) begin
      c[i] = a_q[i] & zpub;
      for (int j = 0; j < N; j++)
        c[i] = c[i] ^ t_q[i][j];
    end
  end

endmodule

// File: rtl/dom_dep_word.sv
// rtl/dom_dep_word.sv - W-bit DOM dependent AND gadget with valid/ready control and optional output register
module dom_dep_word import dom_pkg::*; #(
  parameter int D       = DEF_D,
  parameter int N       = D + 1,
  parameter int L       = n_pairs(D),
  parameter int W       = DEF_W,
  parameter int OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W*N-1:0] port_a,
  input  logic [W*N-1:0] port_b,
  input  logic [W*N-1:0] port_r1,
  input  logic [W*L-1:0] port_r2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W*N-1:0] port_c
);

  logic           v1_q, v1_d;
  logic           adv1;
  logic           accept;
  logic [W*N-1:0] comb_c;

  assign in_ready = !rst && (!v1_q || adv1);
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < W; k++) begin : g_slice
    dom_dep_bit #(.N(N), .L(L)) u_bit (
      .clk (clk),
      .rst (rst),
      .ld  (accept),
      .a   (port_a[share_lsb(k, 0, N) +: N]),
      .b   (port_b[share_lsb(k, 0, N) +: N]),
      .r1  (port_r1[share_lsb(k, 0, N) +: N]),
      .r2  (port_r2[k*L +: L]),
      .c   (comb_c[share_lsb(k, 0, N) +: N])
    );
  end

  always_comb begin
    v1_d = v1_q;
    if (accept)
      v1_d = 1'b1;
    else if (adv1)
      v1_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= v1_d;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic           v2_q, v2_d;
    logic [W*N-1:0] c2_q, c2_d;
    logic           load2;

    assign load2 = v1_q && (!v2_q || out_ready);
    assign adv1  = load2;

    // c2 only changes on a real load so a stalled output never toggles
    always_comb begin
      v2_d = v2_q;
      c2_d = c2_q;
      if (load2) begin
        v2_d = 1'b1;
        c2_d = comb_c;
      end else if (out_ready) begin
        v2_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        c2_q <= '0;
      end else begin
        v2_q <= v2_d;
        c2_q <= c2_d;
      end
    end

    assign out_valid = v2_q;
    assign port_c    = c2_q;
  end else begin : g_comb
    assign adv1      = v1_q && out_ready;
    assign out_valid = v1_q;
    assign port_c    = comb_c;
  end

endmodule

// File: tb/tb_dom_dep_word.sv
// tb/tb_dom_dep_word.sv - directed bench for dom_dep_word with a queue-based unmasked reference model
module tb_dom_dep_word;

  localparam int NA = 2, WA = 4, LA = 1;
  localparam int NB = 3, WB = 8, LB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       in_valid, in_ready, out_valid, out_ready;
  logic [1:0][23:0] pa, pb, pr1, pr2, pc;
  logic [WA*NA-1:0] c_a;
  logic [WB*NB-1:0] c_b;
  logic             ir_a, ir_b, ov_a, ov_b;

  assign in_ready  = {ir_b, ir_a};
  assign out_valid = {ov_b, ov_a};
  assign pc        = {c_b, {16'b0, c_a}};

  dom_dep_word #(.D(1), .W(WA), .OUT_REG(1)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (ir_a),
    .port_a    (pa[0][WA*NA-1:0]),
    .port_b    (pb[0][WA*NA-1:0]),
    .port_r1   (pr1[0][WA*NA-1:0]),
    .port_r2   (pr2[0][WA*LA-1:0]),
    .out_valid (ov_a),
    .out_ready (out_ready[0]),
    .port_c    (c_a)
  );

  dom_dep_word #(.D(2), .W(WB), .OUT_REG(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (ir_b),
    .port_a    (pa[1][WB*NB-1:0]),
    .port_b    (pb[1][WB*NB-1:0]),
    .port_r1   (pr1[1][WB*NB-1:0]),
    .port_r2   (pr2[1][WB*LB-1:0]),
    .out_valid (ov_b),
    .out_ready (out_ready[1]),
    .port_c    (c_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] unmask(input logic [23:0] v, input int w, input int n);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < w; k++)
      for (int i = 0; i < n; i++)
        r[k] = r[k] ^ v[k*n+i];
    return r;
  endfunction

  // Reference model: expected unmasked result and accept cycle per beat, in order
  logic [7:0] q0_c[$], q1_c[$];
  int         q0_t[$], q1_t[$];
  logic [1:0] strict, stall_prev;
  logic [1:0][23:0] c_prev;
  logic       rst_prev = 1'b0;
  int         emitted[2], accepted[2];

  initial begin
    emitted[0] = 0; emitted[1] = 0;
    accepted[0] = 0; accepted[1] = 0;
    stall_prev = '0;
    c_prev = '0;
  end

  task automatic mon(input int d);
    int n, w, lat, t;
    logic [7:0] e;
    n   = (d == 0) ? NA : NB;
    w   = (d == 0) ? WA : WB;
    lat = (d == 0) ? 2 : 1;
    if (rst) begin
      if (d == 0) begin q0_c.delete(); q0_t.delete(); end
      else        begin q1_c.delete(); q1_t.delete(); end
      chk("in_ready_during_rst", in_ready[d], 1'b0);
      stall_prev[d] = 1'b0;
      return;
    end
    if (rst_prev) begin
      chk("out_valid_after_rst", out_valid[d], 1'b0);
      chk("port_c_after_rst", pc[d], 24'h0);
    end
    if (stall_prev[d]) begin
      chk("stall_valid_hold", out_valid[d], 1'b1);
      chk("stall_c_hold", pc[d], c_prev[d]);
    end
    if (out_valid[d] && out_ready[d]) begin
      if ((d == 0 && q0_c.size() == 0) || (d == 1 && q1_c.size() == 0)) begin
        chk("spurious_emit", out_valid[d], 1'b0);
      end else begin
        if (d == 0) begin e = q0_c.pop_front(); t = q0_t.pop_front(); end
        else        begin e = q1_c.pop_front(); t = q1_t.pop_front(); end
        chk("unmasked_c", unmask(pc[d], w, n), e);
        if (strict[d]) chk("latency", cyc - t, lat);
        emitted[d]++;
      end
    end
    stall_prev[d] = out_valid[d] & ~out_ready[d];
    c_prev[d]     = pc[d];
    if (in_valid[d] && in_ready[d]) begin
      e = unmask(pa[d], w, n) & unmask(pb[d], w, n);
      if (d == 0) begin q0_c.push_back(e); q0_t.push_back(cyc); end
      else        begin q1_c.push_back(e); q1_t.push_back(cyc); end
      accepted[d]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    rst_prev = rst;
  end

  task automatic beat(input int d, input logic [7:0] av, input logic [7:0] bv, input logic v);
    int n, w, l;
    logic xa, xb, s;
    n = (d == 0) ? NA : NB;
    w = (d == 0) ? WA : WB;
    l = (d == 0) ? LA : LB;
    pa[d] = '0; pb[d] = '0; pr1[d] = '0; pr2[d] = '0;
    for (int k = 0; k < w; k++) begin
      xa = 1'b0; xb = 1'b0;
      for (int i = 0; i < n - 1; i++) begin
        s = 1'($urandom_range(0, 1)); pa[d][k*n+i] = s; xa = xa ^ s;
        s = 1'($urandom_range(0, 1)); pb[d][k*n+i] = s; xb = xb ^ s;
      end
      pa[d][k*n+n-1] = av[k] ^ xa;
      pb[d][k*n+n-1] = bv[k] ^ xb;
    end
    for (int i = 0; i < w * n; i++) pr1[d][i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < w * l; i++) pr2[d][i] = 1'($urandom_range(0, 1));
    in_valid[d] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         e_base;
  logic [3:0] s0_first;
  logic       s0_varied;

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = 2'b11;
    strict = 2'b11;
    pa = '0; pb = '0; pr1 = '0; pr2 = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid_a", out_valid[0], 1'b0);
    chk("reset_port_c_a", pc[0], 24'h0);
    chk("reset_in_ready_a", in_ready[0], 1'b1);

    // single beat, OUT_REG=1 latency 2
    step(); beat(0, 8'hA, 8'h6, 1'b1);
    step(); in_valid[0] = 1'b0;
    @(negedge clk); chk("t1_ov_lat1", out_valid[0], 1'b0);
    @(negedge clk); chk("t1_ov_lat2", out_valid[0], 1'b1);
    chk("t1_c", unmask(pc[0], WA, NA), 8'h2);
    repeat (3) step();

    // back-to-back stream
    e_base = emitted[0];
    for (int i = 0; i < 16; i++) begin
      step(); beat(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1);
      @(negedge clk); chk("t2_in_ready", in_ready[0], 1'b1);
    end
    step(); in_valid[0] = 1'b0;
    repeat (4) step();
    chk("t2_count", emitted[0] - e_base, 16);

    // stall with a full pipeline
    strict[0] = 1'b0;
    step(); beat(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1);
    step(); beat(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1);
    step(); out_ready[0] = 1'b0; beat(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); chk("t3_in_ready_stalled", in_ready[0], 1'b0);
      step();
      if (s == 4) out_ready[0] = 1'b1;
      beat(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      step(); beat(0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'b1);
    end
    step(); in_valid[0] = 1'b0;
    repeat (5) step();
    chk("t3_no_loss", emitted[0], accepted[0]);
    chk("t3_queue_empty", q0_c.size(), 0);
    strict[0] = 1'b1;

    // randomness independence
    s0_varied = 1'b0;
    s0_first  = 4'h0;
    for (int i = 0; i < 100; i++) begin
      step(); beat(0, 8'hF, 8'h5, 1'b1);
      @(negedge clk);
      if (out_valid[0]) begin
        chk("t4_c", unmask(pc[0], WA, NA), 8'h5);
        if (i == 2) s0_first = {pc[0][6], pc[0][4], pc[0][2], pc[0][0]};
        else if (i > 2 && {pc[0][6], pc[0][4], pc[0][2], pc[0][0]} != s0_first) s0_varied = 1'b1;
      end
    end
    step(); in_valid[0] = 1'b0;
    repeat (4) step();
    chk("t4_shares_vary", s0_varied, 1'b1);

    // reset with two beats in flight
    step(); out_ready[0] = 1'b0; beat(0, 8'h3, 8'h7, 1'b1);
    step(); beat(0, 8'hC, 8'hE, 1'b1);
    step(); in_valid[0] = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    chk("t5_out_valid", out_valid[0], 1'b0);
    chk("t5_port_c", pc[0], 24'h0);
    e_base = emitted[0];
    repeat (4) step();
    chk("t5_no_emit", emitted[0] - e_base, 0);
    step(); beat(0, 8'h9, 8'hB, 1'b1);
    step(); in_valid[0] = 1'b0;
    repeat (4) step();
    chk("t5_next_beat", emitted[0] - e_base, 1);

    // OUT_REG=0, D=2, W=8
    step(); beat(1, 8'hFF, 8'h3C, 1'b1);
    @(negedge clk); chk("t6_ov_before", out_valid[1], 1'b0);
    step(); in_valid[1] = 1'b0;
    @(negedge clk); chk("t6_ov_lat1", out_valid[1], 1'b1);
    chk("t6_c", unmask(pc[1], WB, NB), 8'h3C);
    repeat (2) step();
    strict[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      out_ready[1] = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
      beat(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end
    step(); in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    repeat (4) step();
    chk("t6_no_loss", emitted[1], accepted[1]);
    chk("t6_queue_empty", q1_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
